signed_sort_buffer: RTL

//   Collects a burst of up to DEPTH signed two's-complement words through a valid/ready input port.

---
 rtl/sort_buffer_pkg.sv | 14 +
 rtl/signed_sort_buffer_cell.sv | 54 +++++
 rtl/signed_sort_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/sort_buffer_pkg.sv
// Shared types and the signed compare used by every sort cell.
package sort_buffer_pkg;

  typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} sort_state_t;

  // Operands are sign-extended to this width before comparing, so any N <= SLT_W works.
  localparam int SLT_W = 64;

  function automatic logic slt_signed(input logic signed [SLT_W-1:0] a,
                                      input logic signed [SLT_W-1:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/signed_sort_buffer_cell.sv
// One slot of the insertion-sort buffer: a word, an occupied bit and its insert-before flag.
// Honours SORT_DESCENDING_EN (largest-first ordering).
module sort_cell
  import sort_buffer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic         accept,
  input  logic         pop,
  input  logic [N-1:0] below_data,
  input  logic         below_occ,
  input  logic         below_ins,
  input  logic [N-1:0] above_data,
  input  logic         above_occ,
  output logic [N-1:0] data,
  output logic         occ,
  output logic         ins
);

  logic take_below, take_new;

  // Strict compare keeps equal values stable: the new word lands after existing equals.
`ifdef SORT_DESCENDING_EN
  assign ins = occ && slt_signed(SLT_W'($signed(data)), SLT_W'($signed(x)));
`else
  assign ins = occ && slt_signed(SLT_W'($signed(x)), SLT_W'($signed(data)));
`endif

  // The insertion point takes x; everything past it takes its lower neighbour.
  assign take_below = below_ins;
  assign take_new   = !below_ins && (ins || (!occ && below_occ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      occ  <= 1'b0;
    end else if (pop) begin
      data <= above_data;
      occ  <= above_occ;
    end else if (accept) begin
      if (take_below) begin
        data <= below_data;
        occ  <= 1'b1;
      end else if (take_new) begin
        data <= x;
        occ  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_sort_buffer.sv
// Burst sort buffer: fills by insertion sort, then drains smallest-first (largest-first
// when SORT_DESCENDING_EN is defined).
module signed_sort_buffer
  import sort_buffer_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  sort_state_t                 state;
  logic [DEPTH-1:0][N-1:0]     slot;
  logic [DEPTH-1:0]            occ, ins;
  logic                        accept, pop;

  assign in_ready  = (state == S_FILL);
  assign out_valid = (state == S_DRAIN);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (count == CW'(1));
  assign out_data  = out_valid ? slot[0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
      count <= '0;
    end else if (accept) begin
      count <= count + CW'(1);
      // A full buffer closes the burst even without in_last.
      if (in_last || count == CW'(DEPTH-1)) state <= S_DRAIN;
    end else if (pop) begin
      count <= count - CW'(1);
      if (count == CW'(1)) state <= S_FILL;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [N-1:0] bd, ad;
    logic         bo, bi, ao;

    if (i == 0) begin : g_bot
      // Bottom cell behaves as if an occupied, non-inserting neighbour sits below it.
      assign bd = '0;
      assign bo = 1'b1;
      assign bi = 1'b0;
    end else begin : g_mid
      assign bd = slot[i-1];
      assign bo = occ[i-1];
      assign bi = ins[i-1];
    end

    if (i == DEPTH-1) begin : g_top
      assign ad = '0;
      assign ao = 1'b0;
    end else begin : g_low
      assign ad = slot[i+1];
      assign ao = occ[i+1];
    end

    sort_cell #(.N(N)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (in_data),
      .accept    (accept),
      .pop       (pop),
      .below_data(bd),
      .below_occ (bo),
      .below_ins (bi),
      .above_data(ad),
      .above_occ (ao),
      .data      (slot[i]),
      .occ       (occ[i]),
      .ins       (ins[i])
    );
  end

endmodule
